// File: rtl/cmp_serial.sv
// cmp_serial: multi-cycle comparator. It compares two WIDTH-bit operands
// CHUNK bits per cycle, starting with the most significant chunk, in signed
// or unsigned mode. It produces two 2-bit codes: A vs B (cmp) and A vs 0 (zero).
// Codes: 01 eq, 10 gt, 11 lt, 00 no result.
// Optional build macro CMP_EARLY_EXIT_EN ends the scan as soon as both
// verdicts are known. The default build always takes NCHUNK cycles.
module cmp_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [1:0]       cmp,
    output logic [1:0]       zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] R_NONE = 2'b00;
    localparam logic [1:0] R_EQ   = 2'b01;
    localparam logic [1:0] R_GT   = 2'b10;
    localparam logic [1:0] R_LT   = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state, state_nxt;

    // Operands are held in shift registers. The chunk under test is always
    // at the top, so no variable part-select is needed.
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             sm_q;
    logic             first_q;
    logic [CNT_W-1:0] cnt;

    // Running verdicts: a decided flag plus the fixed value.
    logic             cmp_dec, zero_dec;
    logic [1:0]       cmp_val, zero_val;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] ca_raw, ca, cb;
    logic             cmp_dec_nxt, zero_dec_nxt;
    logic [1:0]       cmp_val_nxt, zero_val_nxt;
    logic [1:0]       cmp_fin, zero_fin;

    // Ordering verdict between two unsigned chunks that are known to differ.
    function automatic logic [1:0] order_verdict(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y);
        return (x > y) ? R_GT : R_LT;
    endfunction

    // Evaluate the current top chunk and fold it into the running verdicts.
    always_comb begin
        ca_raw       = a_sh[WIDTH-1 -: CHUNK];
        ca           = ca_raw;
        cb           = b_sh[WIDTH-1 -: CHUNK];
        // Flipping the sign bit maps two's-complement order onto unsigned order.
        if (first_q && sm_q) begin
            ca[CHUNK-1] = ~ca[CHUNK-1];
            cb[CHUNK-1] = ~cb[CHUNK-1];
        end
        cmp_dec_nxt  = cmp_dec;
        cmp_val_nxt  = cmp_val;
        zero_dec_nxt = zero_dec;
        zero_val_nxt = zero_val;
        if (!cmp_dec && (ca != cb)) begin
            cmp_dec_nxt = 1'b1;
            cmp_val_nxt = order_verdict(ca, cb);
        end
        // A negative signed A was already decided at acceptance.
        // Otherwise any nonzero chunk means A > 0.
        if (!zero_dec && (ca_raw != '0)) begin
            zero_dec_nxt = 1'b1;
            zero_val_nxt = R_GT;
        end
        cmp_fin  = cmp_dec_nxt  ? cmp_val_nxt  : R_EQ;
        zero_fin = zero_dec_nxt ? zero_val_nxt : R_EQ;
`ifdef CMP_EARLY_EXIT_EN
        last = (cnt == '0) || (cmp_dec_nxt && zero_dec_nxt);
`else
        last = (cnt == '0);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs. DONE accepts start exactly like IDLE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = (state == SCAN);
        done      = (state == DONE);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN:    state_nxt = last ? DONE : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, scan datapath and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sm_q     <= 1'b0;
            first_q  <= 1'b0;
            cnt      <= '0;
            cmp_dec  <= 1'b0;
            cmp_val  <= R_NONE;
            zero_dec <= 1'b0;
            zero_val <= R_NONE;
            cmp      <= R_NONE;
            zero     <= R_NONE;
        end else if (accept) begin
            a_sh     <= A;
            b_sh     <= B;
            sm_q     <= signed_mode;
            first_q  <= 1'b1;
            cnt      <= CNT_W'(NCHUNK - 1);
            cmp_dec  <= 1'b0;
            cmp_val  <= R_NONE;
            zero_dec <= signed_mode & A[WIDTH-1];
            zero_val <= (signed_mode & A[WIDTH-1]) ? R_LT : R_NONE;
        end else if (state == SCAN) begin
            a_sh     <= a_sh << CHUNK;
            b_sh     <= b_sh << CHUNK;
            first_q  <= 1'b0;
            cnt      <= cnt - CNT_W'(1);
            cmp_dec  <= cmp_dec_nxt;
            cmp_val  <= cmp_val_nxt;
            zero_dec <= zero_dec_nxt;
            zero_val <= zero_val_nxt;
            if (last) begin
                cmp  <= cmp_fin;
                zero <= zero_fin;
            end
        end
    end

endmodule

// File: tb/tb_cmp_serial.sv
// Scoreboard bench for cmp_serial: a 32/8 instance and a 64/16 instance.
// Drivers push the expected codes and latency when they issue a start.
// Monitors pop the queue and compare whenever done is presented.
module tb_cmp_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1, sm1, busy1, done1;
    logic [31:0] a1, b1;
    logic [1:0]  cmp1, zero1;
    logic        start2, sm2, busy2, done2;
    logic [63:0] a2, b2;
    logic [1:0]  cmp2, zero2;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] c;
        logic [1:0] z;
        int         lat;
        int         e0;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sm;
        logic [1:0]  c;
        logic [1:0]  z;
        int          ln;
        int          le;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[10];

    cmp_serial #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
        .A(a1), .B(b1), .busy(busy1), .done(done1), .cmp(cmp1), .zero(zero1)
    );

    cmp_serial #(.WIDTH(64), .CHUNK(16)) u64 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
        .A(a2), .B(b2), .busy(busy2), .done(done2), .cmp(cmp2), .zero(zero2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_sel(input int ln, input int le);
`ifdef CMP_EARLY_EXIT_EN
        return le;
`else
        return ln;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                           input logic [1:0] c, input logic [1:0] z,
                           input int ln, input int le, input bit push);
        int n = 0;
        while (busy1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy1) chk("issue32_wait_timeout", 32'(busy1), 32'd0);
        a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
        if (push) q1.push_back('{c, z, lat_sel(ln, le), cyc + 1});
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic sm,
                           input logic [1:0] c, input logic [1:0] z,
                           input int ln, input int le);
        int n = 0;
        while (busy2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy2) chk("issue64_wait_timeout", 32'(busy2), 32'd0);
        a2 = a; b2 = b; sm2 = sm; start2 = 1'b1;
        q2.push_back('{c, z, lat_sel(ln, le), cyc + 1});
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0 || busy1 || busy2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q1.size() + q2.size()), 32'd0);
    endtask

    // Monitor for the 32-bit instance.
    always @(negedge clk) begin : mon32
        exp_t e;
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done32_unexpected actual=1 required=0");
            end else begin
                e = q1.pop_front();
                chk("cmp32", 32'(cmp1), 32'(e.c));
                chk("zero32", 32'(zero1), 32'(e.z));
                chk("lat32", 32'(cyc - e.e0), 32'(e.lat));
            end
        end
    end

    // Monitor for the 64-bit instance.
    always @(negedge clk) begin : mon64
        exp_t e;
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done64_unexpected actual=1 required=0");
            end else begin
                e = q2.pop_front();
                chk("cmp64", 32'(cmp2), 32'(e.c));
                chk("zero64", 32'(zero2), 32'(e.z));
                chk("lat64", 32'(cyc - e.e0), 32'(e.lat));
            end
        end
    end

    initial begin
        int n;
        // Fields: a, b, signed, cmp, zero, fixed latency, early-exit latency.
        vecs[0] = '{32'h00000005, 32'h00000005, 1'b1, 2'b01, 2'b10, 4, 4};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 2'b11, 2'b11, 4, 1};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 2'b10, 2'b10, 4, 1};
        vecs[3] = '{32'h00000000, 32'h80000000, 1'b1, 2'b10, 2'b01, 4, 4};
        vecs[4] = '{32'h00000000, 32'h80000000, 1'b0, 2'b11, 2'b01, 4, 4};
        vecs[5] = '{32'h00120000, 32'h00110000, 1'b0, 2'b10, 2'b10, 4, 2};
        vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 2'b10, 2'b10, 4, 1};
        vecs[7] = '{32'h00000100, 32'h00000200, 1'b1, 2'b11, 2'b10, 4, 3};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b1, 2'b01, 2'b11, 4, 4};
        vecs[9] = '{32'h80000000, 32'h80000000, 1'b0, 2'b01, 2'b10, 4, 4};

        reset = 1'b1;
        start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy32", 32'(busy1), 32'd0);
        chk("rst_done32", 32'(done1), 32'd0);
        chk("rst_cmp32", 32'(cmp1), 32'd0);
        chk("rst_zero32", 32'(zero1), 32'd0);
        chk("rst_busy64", 32'(busy2), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors, issued one at a time.
        for (int i = 0; i < 10; i++) begin
            issue32(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].c, vecs[i].z,
                    vecs[i].ln, vecs[i].le, 1'b1);
            drain();
        end

        // A second start while busy is ignored; the first result stands.
        issue32(32'h5, 32'h5, 1'b1, 2'b01, 2'b10, 4, 4, 1'b1);
        a1 = 32'hFFFFFFFF; b1 = 32'h1; sm1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        chk("busy_at_e0p2", 32'(busy1), 32'd1);
        start1 = 1'b0;
        drain();

        // A start during the done cycle is accepted with no lost cycle.
        issue32(32'h5, 32'h5, 1'b1, 2'b01, 2'b10, 4, 4, 1'b1);
        n = 0;
        while (!done1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen_b2b", 32'(done1), 32'd1);
        issue32(32'h00000100, 32'h00000200, 1'b1, 2'b11, 2'b10, 4, 3, 1'b1);
        drain();

        // Reset mid-scan aborts with no done pulse and clears the results.
        issue32(32'hFFFFFFFF, 32'h1, 1'b0, 2'b10, 2'b10, 4, 4, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_cmp", 32'(cmp1), 32'd0);
        chk("abort_zero", 32'(zero1), 32'd0);
        repeat (6) @(negedge clk);
        issue32(32'h0, 32'h80000000, 1'b0, 2'b11, 2'b01, 4, 4, 1'b1);
        drain();

        // Wide instance.
        issue64(64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1, 2'b11, 2'b11, 4, 1);
        drain();
        issue64(64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b0, 2'b10, 2'b10, 4, 1);
        drain();
        issue64(64'h0000000000000000, 64'h0000000000000000, 1'b1, 2'b01, 2'b01, 4, 4);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
